collision_score: RTL and testbench
==================================

Name: collision_score

Overview:
- Game-state stage downstream of square_logic and player_logic, upstream of render_logic and the HEX displays.
- Once per frame, checks each falling square against its player paddle (square 1 vs player x, square 2 vs player x2).
- Counts catches into a 3-digit BCD score and misses against a life counter.
- Runs a PLAY / FLASH / OVER state machine that render_logic uses for feedback.

Parameters:
- SQ_SIZE, 40: square edge length in pixels.
- PAD_W, 80: paddle width in pixels; paddle spans x .. x+PAD_W-1.
- PAD_Y, 540: paddle top row.
- PAD_H, 20: paddle height; paddle spans PAD_Y .. PAD_Y+PAD_H-1.
- LIVES_INIT, 3: lives after reset or restart (1..3).
- FLASH_FRAMES, 30: frames of invulnerability after a miss.

Ports:
- clk, in, 1: pixel clock (VGA_CLK domain).
- rst, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per frame, at vertical blank start.
- restart, in, 1: one-cycle pulse; honoured only in OVER.
- px1, in, 10: player 1 paddle left x.
- px2, in, 10: player 2 paddle left x.
- sq1_x, sq1_y, in, 10 each: square 1 top-left.
- sq2_x, sq2_y, in, 10 each: square 2 top-left.
- score_bcd, out, 12: three BCD digits, [11:8] hundreds.
- lives, out, 2: remaining lives.
- catch1, catch2, out, 1 each: one-cycle catch pulses.
- miss_pulse, out, 1: one-cycle pulse when any miss is charged.
- flash, out, 1: high in FLASH state.
- game_over, out, 1: high in OVER state.

Behaviour:
- Reset values:
  - score_bcd = 12'h000, lives = LIVES_INIT.
  - All pulses 0, flash 0, game_over 0.
  - State PLAY, armed1 = armed2 = 1, flash counter 0.
- Evaluation timing:
  - Inputs are sampled only on the cycle frame_tick = 1.
  - Outputs update exactly 1 cycle later; pulses last exactly 1 cycle.
- Arithmetic: all geometry compares use 11-bit zero-extended operands so x+width never wraps.
- Overlap for square n:
  - vertical: sqn_y+SQ_SIZE > PAD_Y AND sqn_y < PAD_Y+PAD_H;
  - horizontal: sqn_x+SQ_SIZE > pxn AND sqn_x < pxn+PAD_W.
- Catch: overlap AND armedn -> catchn = 1, armedn cleared.
- Miss: armedn AND sqn_y >= PAD_Y+PAD_H -> armedn cleared; a life is charged unless the state is FLASH.
- Re-arm: sqn_y+SQ_SIZE <= PAD_Y with armedn = 0 -> armedn = 1. This covers the square respawning at the top.
- Score:
  - Add catch1+catch2 (0, 1 or 2) in BCD in a single cycle.
  - Saturate at 999; no wrap.
- Lives:
  - Subtract the charged misses (0..2), saturating at 0.
  - miss_pulse = 1 if at least one miss is charged.
- States:
  - PLAY: a charged miss with lives_next > 0 -> FLASH, counter loaded with FLASH_FRAMES-1. A charged miss with lives_next = 0 -> OVER.
  - FLASH: catches still count. Misses clear armed but are not charged and do not pulse miss_pulse. Counter decrements on each frame_tick; at 0 on a frame_tick -> PLAY.
  - OVER: game_over = 1, score and lives frozen, no catch or miss pulses. restart -> PLAY with score 0, lives LIVES_INIT, both armed. restart outside OVER is ignored.
- Simultaneous events:
  - Catch on one square and miss on the other in the same frame: both applied.
  - Two misses with lives = 1: lives = 0, go to OVER.
  - restart coinciding with frame_tick in OVER: restart wins; no evaluation that frame.
- rst mid-frame or mid-FLASH: returns to the reset values on the next edge, with no pulses.

Decomposition:
- Shared package game_pkg holds:
  - state encoding (ST_PLAY, ST_FLASH, ST_OVER);
  - geometry defaults (SQ_SIZE, PAD_W, PAD_Y, PAD_H), shared with square_logic and render_logic.
- One sub-module, bcd_sat_add3: a 3-digit BCD accumulator with increment 0..2, saturating at 999, with synchronous clear.

Test Plan:
1. Catch: px1 = 300, sq1 = (320, 520), frame_tick -> catch1 = 1 one cycle later, score_bcd = 12'h001. A second tick at the same position -> no pulse (disarmed).
2. Miss and flash: sq2 = (100, 560), px2 = 400, lives = 3 -> miss_pulse = 1, lives = 2, flash = 1. A second miss within 30 ticks -> lives stays 2. flash drops after the 30th tick.
3. Re-arm: after the catch in test 1, sq1_y = 0, tick, then sq1_y = 520, tick -> catch1 = 1 again, score = 12'h002.
4. BCD carry and saturation:
   - preload to 099, dual catch -> 12'h101;
   - at 998, dual catch -> 12'h999;
   - a further catch -> stays 12'h999.
5. Game over: lives = 1 in PLAY, both squares miss on one tick -> lives = 0, game_over = 1. Later catches are ignored. restart -> score 000, lives 3, game_over = 0 next cycle.
6. Reset mid-FLASH: rst = 1 for one cycle -> flash = 0, lives = 3, score = 000, state PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-state definitions: FSM encoding, default playfield geometry and
// the per-square collision evaluation used by the scoring stage.
package game_pkg;

  localparam int DEF_SQ_SIZE      = 40;
  localparam int DEF_PAD_W        = 80;
  localparam int DEF_PAD_Y        = 540;
  localparam int DEF_PAD_H        = 20;
  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_FLASH_FRAMES = 30;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FLASH = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  typedef struct packed {
    logic catch_hit;
    logic miss;
    logic rearm;
  } sq_eval_t;

  // Geometry is widened to 11 bits so that x+width cannot wrap past 1023.
  function automatic sq_eval_t eval_square(
    input logic [9:0]  x,
    input logic [9:0]  y,
    input logic [9:0]  px,
    input logic        armed,
    input logic [10:0] sq_size,
    input logic [10:0] pad_w,
    input logic [10:0] pad_y,
    input logic [10:0] pad_h
  );
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] p11;
    logic        vert;
    logic        horiz;
    sq_eval_t    r;
    x11         = {1'b0, x};
    y11         = {1'b0, y};
    p11         = {1'b0, px};
    vert        = (y11 + sq_size > pad_y) && (y11 < pad_y + pad_h);
    horiz       = (x11 + sq_size > p11) && (x11 < p11 + pad_w);
    r.catch_hit = armed && vert && horiz;
    r.miss      = armed && (y11 >= pad_y + pad_h);
    r.rearm     = !armed && (y11 + sq_size <= pad_y);
    return r;
  endfunction

endpackage

// File: rtl/bcd_sat_add3.sv
// Three-digit BCD accumulator: adds 0..2 per cycle, saturates at 999,
// synchronous clear takes priority over the increment.
module bcd_sat_add3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [1:0]  inc,
  output logic [11:0] sum
);

  logic [11:0] sum_q;
  logic [11:0] sum_d;
  logic [4:0]  dsum;
  logic [1:0]  carry;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sum_d = sum_q;
    carry = inc;
    dsum  = '0;
    for (int d = 0; d < 3; d++) begin
      dsum = {1'b0, sum_q[4*d +: 4]} + {3'b000, carry};
      if (dsum > 5'd9) begin
        sum_d[4*d +: 4] = 4'(dsum - 5'd10);
        carry           = 2'd1;
      end else begin
        sum_d[4*d +: 4] = dsum[3:0];
        carry           = 2'd0;
      end
    end
    // A carry out of the hundreds digit means the true sum passed 999.
    if (carry != 2'd0) sum_d = 12'h999;
    if (clr)           sum_d = 12'h000;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) sum_q <= 12'h000;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/collision_score.sv
// Per-frame paddle/square collision check feeding a BCD score, a life counter
// and the PLAY / FLASH / OVER game state consumed by the renderer.
module collision_score
  import game_pkg::*;
#(
  parameter int SQ_SIZE      = DEF_SQ_SIZE,
  parameter int PAD_W        = DEF_PAD_W,
  parameter int PAD_Y        = DEF_PAD_Y,
  parameter int PAD_H        = DEF_PAD_H,
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic [9:0]  px1,
  input  logic [9:0]  px2,
  input  logic [9:0]  sq1_x,
  input  logic [9:0]  sq1_y,
  input  logic [9:0]  sq2_x,
  input  logic [9:0]  sq2_y,
  output logic [11:0] score_bcd,
  output logic [1:0]  lives,
  output logic        catch1,
  output logic        catch2,
  output logic        miss_pulse,
  output logic        flash,
  output logic        game_over
);

  localparam logic [10:0] SQ_W  = 11'(SQ_SIZE);
  localparam logic [10:0] PW_W  = 11'(PAD_W);
  localparam logic [10:0] PY_W  = 11'(PAD_Y);
  localparam logic [10:0] PH_W  = 11'(PAD_H);
  localparam int          CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [1:0]  LIVES_RST  = 2'(LIVES_INIT);

  state_e           state_q, state_d;
  logic [1:0]       armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic [1:0]       catch_q, catch_d;
  logic             miss_q, miss_d;
  logic             flash_q, flash_d;
  logic             game_over_q, game_over_d;

  sq_eval_t         sq_ev [2];
  logic [1:0]       charged;
  logic [1:0]       score_inc;
  logic             score_clr;

  always_comb begin
    sq_ev[0] = eval_square(sq1_x, sq1_y, px1, armed_q[0], SQ_W, PW_W, PY_W, PH_W);
    sq_ev[1] = eval_square(sq2_x, sq2_y, px2, armed_q[1], SQ_W, PW_W, PY_W, PH_W);

    state_d   = state_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    catch_d   = 2'b00;
    miss_d    = 1'b0;
    charged   = 2'd0;
    score_inc = 2'd0;
    score_clr = 1'b0;

    if (state_q == ST_OVER) begin
      // Restart pre-empts any coinciding frame evaluation.
      if (restart) begin
        state_d   = ST_PLAY;
        lives_d   = LIVES_RST;
        armed_d   = 2'b11;
        score_clr = 1'b1;
      end
    end else if (frame_tick) begin
      for (int i = 0; i < 2; i++) begin
        catch_d[i] = sq_ev[i].catch_hit;
        if (sq_ev[i].catch_hit || sq_ev[i].miss) armed_d[i] = 1'b0;
        else if (sq_ev[i].rearm)                 armed_d[i] = 1'b1;
      end
      score_inc = {1'b0, catch_d[0]} + {1'b0, catch_d[1]};

      if (state_q == ST_FLASH) begin
        if (cnt_q == '0) state_d = ST_PLAY;
        else             cnt_d   = cnt_q - 1'b1;
      end else begin
        charged = {1'b0, sq_ev[0].miss} + {1'b0, sq_ev[1].miss};
        if (charged != 2'd0) begin
          miss_d  = 1'b1;
          lives_d = (lives_q > charged) ? lives_q - charged : 2'd0;
          if (lives_d == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_FLASH;
            cnt_d   = FLASH_LOAD;
          end
        end
      end
    end

    flash_d     = (state_d == ST_FLASH);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PLAY;
      armed_q     <= 2'b11;
      cnt_q       <= '0;
      lives_q     <= LIVES_RST;
      catch_q     <= 2'b00;
      miss_q      <= 1'b0;
      flash_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      catch_q     <= catch_d;
      miss_q      <= miss_d;
      flash_q     <= flash_d;
      game_over_q <= game_over_d;
    end
  end

  bcd_sat_add3 u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .sum (score_bcd)
  );

  assign lives      = lives_q;
  assign catch1     = catch_q[0];
  assign catch2     = catch_q[1];
  assign miss_pulse = miss_q;
  assign flash      = flash_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_collision_score.sv
// Self-checking bench for collision_score: directed scenarios with literal
// expectations, then randomized frames compared against an integer game model.
module tb_collision_score;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        restart;
  logic [9:0]  px1, px2, sq1_x, sq1_y, sq2_x, sq2_y;
  logic [11:0] score_bcd;
  logic [1:0]  lives;
  logic        catch1, catch2, miss_pulse, flash, game_over;

  int checks = 0;
  int errors = 0;

  collision_score dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .restart    (restart),
    .px1        (px1),
    .px2        (px2),
    .sq1_x      (sq1_x),
    .sq1_y      (sq1_y),
    .sq2_x      (sq2_x),
    .sq2_y      (sq2_y),
    .score_bcd  (score_bcd),
    .lives      (lives),
    .catch1     (catch1),
    .catch2     (catch2),
    .miss_pulse (miss_pulse),
    .flash      (flash),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Game model: plain integer score/lives, a frame countdown for the flash
  // window and a flag for game over.
  int  m_score, m_lives, m_flash_left;
  bit  m_flashing, m_over, m_valid;
  bit  m_armed [2];
  bit  m_catch [2];
  bit  m_miss;

  always @(posedge clk) begin : model
    int xs [2];
    int ys [2];
    int ps [2];
    int misses, catches;
    bit ov;
    if (rst) begin
      m_score = 0; m_lives = 3; m_flash_left = 0;
      m_flashing = 0; m_over = 0; m_valid = 1;
      m_armed[0] = 1; m_armed[1] = 1;
      m_catch[0] = 0; m_catch[1] = 0; m_miss = 0;
    end else begin
      m_catch[0] = 0; m_catch[1] = 0; m_miss = 0;
      if (m_over) begin
        if (restart) begin
          m_over = 0; m_score = 0; m_lives = 3;
          m_armed[0] = 1; m_armed[1] = 1;
        end
      end else if (frame_tick) begin
        xs[0] = int'(sq1_x); ys[0] = int'(sq1_y); ps[0] = int'(px1);
        xs[1] = int'(sq2_x); ys[1] = int'(sq2_y); ps[1] = int'(px2);
        misses = 0; catches = 0;
        for (int i = 0; i < 2; i++) begin
          ov = (ys[i] + 40 > 540) && (ys[i] < 560) && (xs[i] + 40 > ps[i]) && (xs[i] < ps[i] + 80);
          if (m_armed[i] && ov) begin
            m_catch[i] = 1; m_armed[i] = 0; catches++;
          end else if (m_armed[i] && ys[i] >= 560) begin
            m_armed[i] = 0; misses++;
          end else if (!m_armed[i] && ys[i] + 40 <= 540) begin
            m_armed[i] = 1;
          end
        end
        m_score = m_score + catches;
        if (m_score > 999) m_score = 999;
        if (m_flashing) begin
          if (m_flash_left == 0) m_flashing = 0;
          else m_flash_left--;
        end else if (misses > 0) begin
          m_miss = 1;
          m_lives = m_lives - misses;
          if (m_lives < 0) m_lives = 0;
          if (m_lives == 0) m_over = 1;
          else begin
            m_flashing = 1;
            m_flash_left = 29;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("score_bcd",  score_bcd,  to_bcd(m_score));
      check("lives",      lives,      m_lives);
      check("catch1",     catch1,     m_catch[0]);
      check("catch2",     catch2,     m_catch[1]);
      check("miss_pulse", miss_pulse, m_miss);
      check("flash",      flash,      m_flashing);
      check("game_over",  game_over,  m_over);
    end
  end

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic catch_round(input bit both);
    sq1_y = 10'd520;
    if (both) sq2_y = 10'd520;
    tick();
    sq1_y = 10'd0;
    sq2_y = 10'd0;
    tick();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int y_tbl [12];
    int xv;
    y_tbl = '{0, 100, 499, 500, 501, 520, 540, 559, 560, 561, 600, 1000};
    rst = 1'b1; frame_tick = 1'b0; restart = 1'b0;
    px1 = '0; px2 = '0; sq1_x = '0; sq1_y = '0; sq2_x = '0; sq2_y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_score", score_bcd, 12'h000);
    check("rst_lives", lives, 2'd3);
    check("rst_flash", flash, 1'b0);
    check("rst_over",  game_over, 1'b0);

    // Catch, then no repeat while disarmed.
    px1 = 10'd300; sq1_x = 10'd320; sq1_y = 10'd520;
    tick();
    check("t1_catch1", catch1, 1'b1);
    check("t1_score", score_bcd, 12'h001);
    tick();
    check("t1_nocatch", catch1, 1'b0);
    check("t1_score2", score_bcd, 12'h001);

    // Re-arm at the top, catch again.
    sq1_y = 10'd0; tick();
    sq1_y = 10'd520; tick();
    check("t3_catch1", catch1, 1'b1);
    check("t3_score", score_bcd, 12'h002);
    sq1_y = 10'd0; tick();

    // Miss and flash window.
    px2 = 10'd400; sq2_x = 10'd100; sq2_y = 10'd560;
    tick();
    check("t2_miss", miss_pulse, 1'b1);
    check("t2_lives", lives, 2'd2);
    check("t2_flash", flash, 1'b1);
    sq2_y = 10'd0; tick();
    sq2_y = 10'd560; tick();
    check("t2_nomiss", miss_pulse, 1'b0);
    check("t2_lives2", lives, 2'd2);
    sq2_y = 10'd0;
    repeat (27) tick();
    check("t2_flash29", flash, 1'b1);
    tick();
    check("t2_flash30", flash, 1'b0);

    // BCD carry and saturation.
    sq1_x = 10'd320; sq2_x = 10'd420; px2 = 10'd400;
    repeat (48) catch_round(1'b1);
    catch_round(1'b0);
    check("t4_099", score_bcd, 12'h099);
    catch_round(1'b1);
    check("t4_101", score_bcd, 12'h101);
    repeat (448) catch_round(1'b1);
    catch_round(1'b0);
    check("t4_998", score_bcd, 12'h998);
    catch_round(1'b1);
    check("t4_999", score_bcd, 12'h999);
    catch_round(1'b0);
    check("t4_sat", score_bcd, 12'h999);

    // Down to one life, then a double miss ends the game.
    sq2_y = 10'd560; tick();
    check("t5_lives1", lives, 2'd1);
    sq2_y = 10'd0;
    repeat (30) tick();
    check("t5_play", flash, 1'b0);
    sq1_y = 10'd600; sq2_y = 10'd600; tick();
    check("t5_lives0", lives, 2'd0);
    check("t5_over", game_over, 1'b1);
    sq1_y = 10'd520; sq2_y = 10'd520; tick();
    check("t5_ignored", catch1, 1'b0);
    check("t5_frozen", score_bcd, 12'h999);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("t5_rs_score", score_bcd, 12'h000);
    check("t5_rs_lives", lives, 2'd3);
    check("t5_rs_over", game_over, 1'b0);

    // Reset while flashing.
    sq1_y = 10'd0; sq2_y = 10'd0; tick();
    sq1_y = 10'd520; tick();
    sq2_y = 10'd560; tick();
    check("t6_flash", flash, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_flash0", flash, 1'b0);
    check("t6_lives", lives, 2'd3);
    check("t6_score", score_bcd, 12'h000);
    check("t6_over", game_over, 1'b0);

    // Randomized frames against the model.
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 2) == 0);
      restart    = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 1999) == 0);
      if (frame_tick) begin
        px1 = 10'($urandom_range(0, 943));
        px2 = 10'($urandom_range(0, 943));
        xv = int'(px1) + int'($urandom_range(0, 160)) - 60;
        if (xv < 0) xv = 0;
        if (xv > 1023) xv = 1023;
        sq1_x = 10'(xv);
        xv = int'(px2) + int'($urandom_range(0, 160)) - 60;
        if (xv < 0) xv = 0;
        if (xv > 1023) xv = 1023;
        sq2_x = 10'(xv);
        sq1_y = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'(y_tbl[$urandom_range(0, 11)]);
        sq2_y = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'(y_tbl[$urandom_range(0, 11)]);
      end
    end
    @(negedge clk);
    frame_tick = 1'b0; restart = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
